// File: rtl/i4001_bus_responder.sv
// 4001-style ROM bus responder: tracks the 4004 bus phases, returns the addressed ROM byte in M1/M2.
// Optional I/O port (SRC/WRR/RDR) is built only when I4001_IO_PORT_EN is defined.
module i4001_bus_responder #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SYNC,
  input  logic       CM_ROM,
  input  logic [3:0] D_IN,
  output logic [3:0] D_OUT,
  output logic       D_OE,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] io_in,
  output logic [3:0] io_out
);

  typedef enum logic [3:0] {IDLE, A1, A2, A3, M1, M2, X1, X2, X3} phase_t;

  phase_t     phase, phase_nxt;
  logic [7:0] addr, data_q, data_nxt;
  logic [3:0] opr, opa, out_nxt;
  logic       selected, sel_nxt, oe_nxt;
  logic       io_drive;
  logic [3:0] io_drive_val;

  assign rom_addr = addr;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) phase <= IDLE;
    else       phase <= phase_nxt;
  end

  // Outputs are computed for the phase being entered so they hold for that whole phase.
  always_comb begin
    phase_nxt = IDLE;
    if (SYNC) phase_nxt = A1;
    else begin
      case (phase)
        A1:      phase_nxt = A2;
        A2:      phase_nxt = A3;
        A3:      phase_nxt = M1;
        M1:      phase_nxt = M2;
        M2:      phase_nxt = X1;
        X1:      phase_nxt = X2;
        X2:      phase_nxt = X3;
        default: phase_nxt = IDLE;
      endcase
    end
    sel_nxt  = (phase == A3) ? (CM_ROM && D_IN == CHIP_ID) : selected;
    data_nxt = (phase == A3) ? rom_data : data_q;
    oe_nxt   = 1'b0;
    out_nxt  = 4'h0;
    case (phase_nxt)
      M1: if (sel_nxt) begin oe_nxt = 1'b1; out_nxt = data_nxt[7:4]; end
      M2: if (sel_nxt) begin oe_nxt = 1'b1; out_nxt = data_nxt[3:0]; end
      X2: if (io_drive) begin oe_nxt = 1'b1; out_nxt = io_drive_val; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr     <= 8'h00;
      data_q   <= 8'h00;
      opr      <= 4'h0;
      opa      <= 4'h0;
      selected <= 1'b0;
      D_OE     <= 1'b0;
      D_OUT    <= 4'h0;
    end else begin
      selected <= sel_nxt;
      data_q   <= data_nxt;
      D_OE     <= oe_nxt;
      D_OUT    <= out_nxt;
      case (phase)
        A1: addr[3:0] <= D_IN;
        A2: addr[7:4] <= D_IN;
        M1: opr       <= D_IN;
        M2: opa       <= D_IN;
        default: ;
      endcase
    end
  end

`ifdef I4001_IO_PORT_EN
  logic src_match;
  logic is_src, is_wrr, is_rdr;

  assign is_src       = (opr == 4'b0010) && opa[0];
  assign is_wrr       = (opr == 4'b1110) && (opa == 4'b0010);
  assign is_rdr       = (opr == 4'b1110) && (opa == 4'b1010);
  assign io_drive     = is_rdr && src_match;
  assign io_drive_val = io_in;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      src_match <= 1'b0;
      io_out    <= 4'h0;
    end else if (phase == X2) begin
      if (is_src && CM_ROM)          src_match <= (D_IN == CHIP_ID);
      else if (is_wrr && src_match)  io_out    <= D_IN;
    end
  end
`else
  logic unused_io;
  assign unused_io    = ^{io_in, opr, opa};
  assign io_drive     = 1'b0;
  assign io_drive_val = 4'h0;
  assign io_out       = 4'h0;
`endif

endmodule

// File: doc/i4001_bus_responder.md
I4001_BUS_RESPONDER -- requirements
Module: i4001_bus_responder

Interface
REQ-001 Parameter CHIP_ID, default 4'h0, ROM chip number this instance answers to.
REQ-002 CLK  input  1  system clock; one rising edge = one bus phase.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 SYNC  input  1  cycle marker from the 4004 initiator; high during X3 of the preceding cycle.
REQ-005 CM_ROM  input  1  ROM command line from the initiator.
REQ-006 D_IN  input  4  resolved 4-bit data bus value.
REQ-007 D_OUT  output  4  value this block drives onto the bus.
REQ-008 D_OE  output  1  bus drive enable for D_OUT.
REQ-009 rom_addr  output  8  byte address to the ROM array.
REQ-010 rom_data  input  8  ROM byte at rom_addr, bit 7 = OPR msb; valid one CLK after rom_addr changes.
REQ-011 io_in  input  4  I/O port input pins.
REQ-012 io_out  output  4  I/O port output latch.

Function
REQ-013 Phase FSM states: IDLE, A1, A2, A3, M1, M2, X1, X2, X3, encoded in a 4-bit phase register.
REQ-014 SYNC sampled high on a CLK edge -> next phase A1, from any state, including mid-cycle (resynchronisation).
REQ-015 Without SYNC: A1->A2->A3->M1->M2->X1->X2->X3 in sequence; X3 with SYNC low -> IDLE; IDLE holds until SYNC.
REQ-016 A1 edge: addr[3:0] <= D_IN; A2 edge: addr[7:4] <= D_IN; rom_addr = addr register, updates on the A2 edge.
REQ-017 A3 edge: selected <= (CM_ROM == 1 && D_IN == CHIP_ID); data_q <= rom_data.
REQ-018 M1: if selected, D_OE=1, D_OUT=data_q[7:4]; M2: if selected, D_OE=1, D_OUT=data_q[3:0].
REQ-019 D_OE=0 and D_OUT=0 in every other phase, unless REQ-024 applies.
REQ-020 All instances, selected or not, capture opr <= D_IN on the M1 edge and opa <= D_IN on the M2 edge.
REQ-021 D_OE and D_OUT are registered; their values for a phase are valid for that entire phase.
REQ-022 Address wrap: none; rom_addr is 8 bits, and the initiator owns the page (chip) bits.

Reset
REQ-023 RESET high forces immediately: phase=IDLE, addr=0, rom_addr=0, data_q=0, opr=0, opa=0, selected=0, src_match=0, D_OE=0, D_OUT=0, io_out=0; RESET mid-cycle aborts any drive within the same cycle.

Configuration
REQ-024 Macro I4001_IO_PORT_EN: when defined, the block implements the I/O port as follows:
- SRC (opr=0010, opa[0]=1) with CM_ROM=1 at the X2 edge: src_match <= (D_IN == CHIP_ID).
- WRR (opr=1110, opa=0010) with src_match=1 at the X2 edge: io_out <= D_IN.
- RDR (opr=1110, opa=1010) with src_match=1: D_OE=1, D_OUT=io_in during X2.
- src_match persists until the next SRC or RESET.
REQ-025 When I4001_IO_PORT_EN is undefined: no src_match logic, io_out is tied to 0, io_in is ignored, and the block never drives in X phases.

Verification
REQ-026 CHIP_ID=3, rom_data at address 0x5A = 0xD7; bus A1=A, A2=5, A3=3, CM_ROM=1 -> rom_addr=0x5A, D_OE=1 with D_OUT=D in M1 and D_OUT=7 in M2.
REQ-027 Same sequence with A3=2 -> D_OE=0 in all phases; opr=D and opa=7 are still captured from the bus.
REQ-028 SYNC asserted during M1 -> next phase is A1 and D_OE drops; SYNC absent at X3 -> IDLE with no drive until SYNC returns.
REQ-029 RESET pulsed during M2 while driving -> D_OE=0 immediately; all registers are at reset values; normal decode resumes at the next SYNC.
REQ-030 I4001_IO_PORT_EN defined, CHIP_ID=3: SRC with X2 bus=3, then WRR with X2 bus=9 -> io_out=9; RDR with io_in=6 -> D_OE=1, D_OUT=6 in X2. Same stimulus with the macro undefined -> io_out stays 0 and no X-phase drive.
